mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the multicycle RISC processor's memory port. It accepts the controller's `mem_en`/`read_wbar` requests with address and write data, inserts a programmable number of wait states, and performs single-word reads and writes on an internal word-addressed array. It returns completion with a one-cycle `ready` pulse. It sits opposite the processor's datapath memory interface and replaces the zero-latency memory model, so the controller's wait handling can be exercised.

## Interface
- `DATA_W`, default 16: word width. Matches the 16-bit instruction and register width.
- `ADDR_W`, default 16: width of the incoming address bus.
- `DEPTH_LOG2`, default 8: the array holds 2**DEPTH_LOG2 words.
- `WAIT_STATES`, default 2: number of wait cycles W between acceptance and response. Legal range is 0 to 15.
- `clk`  input  1  system clock. All state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `mem_en`  input  1  request valid, driven by the initiator.
- `read_wbar`  input  1  operation select: 1 = read, 0 = write.
- `addr`  input  ADDR_W  word address.
- `wdata`  input  DATA_W  write data.
- `rdata`  output  DATA_W  read data. Registered; holds its value until the next read completes.
- `ready`  output  1  one-cycle completion pulse.
- `busy`  output  1  high whenever the state is not IDLE.
- `err`  output  1  out-of-range flag. Only asserted together with `ready`.

## Operation
- **States**
  - IDLE → WAIT when `mem_en`=1 is sampled and W>0.
  - IDLE → RESP when `mem_en`=1 is sampled and W=0.
  - WAIT → RESP when the wait counter reaches 0.
  - RESP → IDLE unconditionally.
- **Acceptance edge:** `addr`, `wdata` and `read_wbar` are captured, and the 4-bit wait counter is loaded with W-1.
- **WAIT:** the counter decrements once per cycle. `mem_en` and the bus inputs are ignored.
- **Array access:** performed on the edge entering RESP, using the captured values.
  - For W=0 this is the acceptance edge itself, and the live inputs are used.
  - Write: `mem[addr[DEPTH_LOG2-1:0]] <= wdata`. `rdata` is unchanged.
  - Read: `rdata <= mem[addr[DEPTH_LOG2-1:0]]`.
- **RESP:** `ready`=1 for exactly one cycle. `mem_en` is ignored in this state.
- **Initiator obligations:**
  - Hold `addr`, `wdata` and `read_wbar` stable from the acceptance cycle until `ready`.
  - Drop `mem_en` before the edge that ends the first IDLE cycle after `ready`. If `mem_en` is still high at that edge, it is accepted as a new request.
- **Reset values:**
  - State = IDLE.
  - `ready`, `busy` and `err` = 0.
  - `rdata` = 0.
  - Counter = 0.
- **Reset during WAIT:** a pending operation is discarded; a pending write is never committed. The array contents are not cleared by reset.
- **Power-up contents:** undefined; reads of unwritten locations return X in simulation.

## Timing
- Cycle 0 is the cycle in which `mem_en`=1 is sampled in IDLE; `busy`=0 during it.
- Cycles 1..W: WAIT, `busy`=1.
- Cycle W+1: RESP, with `busy`=1 and `ready`=1. `rdata` (for a read) and `err` are valid in this cycle.
- Cycle W+2: IDLE.
- Latency from request to `ready` is W+1 cycles.
- Minimum request period with `mem_en` held high is W+2 cycles.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- **`MEM_ERR_CHECK_EN` defined:**
  - An address with any bit in `addr[ADDR_W-1:DEPTH_LOG2]` set is out of range.
  - On an out-of-range request, the write is suppressed, `rdata` is loaded with 0, and `err`=1 during the RESP cycle.
  - Timing is identical to an in-range access.
- **`MEM_ERR_CHECK_EN` undefined:**
  - Upper address bits are ignored, so addresses alias modulo 2**DEPTH_LOG2.
  - `err` is tied to 0.

## Test plan
- **Reset:** assert `reset`=0 for 3 cycles, then release → `rdata`=0x0000, `ready`=`busy`=`err`=0, state IDLE.
- **Write then read (W=2):**
  - Write 0xBEEF to 0x00A5 → `ready` high in cycle 3 only; `busy` high in cycles 1–3.
  - Then read 0x00A5 → `rdata`=0xBEEF in cycle 3, held afterwards.
- **Back-to-back:** hold `mem_en`=1 through two reads of 0x0001 and 0x0002 (preloaded with 0x1111 and 0x2222) → `ready` in cycles 3 and 7, returning 0x1111 then 0x2222.
- **Out of range (DEPTH_LOG2=8):** write 0xDEAD to 0x0100, then read 0x0000 (previously written 0x5A5A).
  - With the macro: `err`=1 with `ready` on the write, and the read returns 0x5A5A.
  - Without the macro: `err`=0, and the read returns 0xDEAD.
- **Reset mid-write:** 0x0010 holds 0x5555; request a write of 0x1234 to it and pull `reset` low in cycle 1 → after release, a read of 0x0010 returns 0x5555.
- **W=0 build:** read request sampled in cycle 0 → `ready` and valid `rdata` in cycle 1, IDLE in cycle 2.

Source files
------------

// File: rtl/mem_responder.sv
// Wait-state memory responder: single-word read/write with a ready pulse.
// Build option MEM_ERR_CHECK_EN flags out-of-range addresses with err.
module mem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_en,
  input  logic              read_wbar,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WLOAD =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic rd_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic oor_q;
  logic [DATA_W-1:0] rdata_q;
  logic err_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic cap, acc, from_idle;
  logic live_oor;
  logic op_rd, op_oor;
  logic [DEPTH_LOG2-1:0] op_idx;
  logic [DATA_W-1:0] op_wdata;

`ifdef MEM_ERR_CHECK_EN
  assign live_oor = |addr[ADDR_W-1:DEPTH_LOG2];
`else
  logic unused_addr;
  assign unused_addr = ^addr[ADDR_W-1:DEPTH_LOG2];
  assign live_oor = 1'b0;
`endif

  // W=0 accesses straight from IDLE, so operands come from the live bus
  assign from_idle = (state_q == S_IDLE);
  assign op_rd    = from_idle ? read_wbar : rd_q;
  assign op_idx   = from_idle ? addr[DEPTH_LOG2-1:0] : idx_q;
  assign op_wdata = from_idle ? wdata : wdata_q;
  assign op_oor   = from_idle ? live_oor : oor_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    acc     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mem_en) begin
          cap = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            acc     = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WLOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          acc     = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap) begin
        rd_q    <= read_wbar;
        idx_q   <= addr[DEPTH_LOG2-1:0];
        wdata_q <= wdata;
        oor_q   <= live_oor;
      end
      if (acc && op_rd) begin
        rdata_q <= op_oor ? '0 : mem[op_idx];
      end
      err_q <= acc & op_oor;
    end
  end

  // Array is never cleared; gating on reset keeps a held-off write dropped
  always_ff @(posedge clk) begin
    if (reset && acc && !op_rd && !op_oor) begin
      mem[op_idx] <= op_wdata;
    end
  end

  assign rdata = rdata_q;
  assign ready = (state_q == S_RESP);
  assign busy  = (state_q != S_IDLE);
  assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: W=2 instance plus a W=0 instance.
module tb_mem_responder;

  localparam int W = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic        mem_en = 1'b0, read_wbar = 1'b1;
  logic [15:0] addr = '0, wdata = '0;
  logic [15:0] rdata;
  logic        ready, busy, err;

  logic        mem_en0 = 1'b0, read_wbar0 = 1'b1;
  logic [15:0] addr0 = '0, wdata0 = '0;
  logic [15:0] rdata0;
  logic        ready0, busy0, err0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_responder #(.WAIT_STATES(W)) u_dut (
    .clk(clk), .reset(reset), .mem_en(mem_en),
    .read_wbar(read_wbar), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .busy(busy), .err(err)
  );

  mem_responder #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .mem_en(mem_en0),
    .read_wbar(read_wbar0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full request on the W=2 instance with cycle-by-cycle checks
  task automatic req(input string tag, input logic rd,
                     input logic [15:0] a, input logic [15:0] d,
                     input logic [15:0] exp_rd, input logic exp_err);
    mem_en = 1'b1;
    read_wbar = rd;
    addr = a;
    wdata = d;
    chk({tag, ".c0_busy"}, 32'(busy), 32'd0);
    for (int c = 1; c <= W; c++) begin
      step();
      chk({tag, ".wait_busy"}, 32'(busy), 32'd1);
      chk({tag, ".wait_ready"}, 32'(ready), 32'd0);
    end
    step();
    chk({tag, ".resp_ready"}, 32'(ready), 32'd1);
    chk({tag, ".resp_busy"}, 32'(busy), 32'd1);
    chk({tag, ".resp_err"}, 32'(err), 32'(exp_err));
    if (rd) chk({tag, ".rdata"}, 32'(rdata), 32'(exp_rd));
    mem_en = 1'b0;
    step();
    chk({tag, ".idle_ready"}, 32'(ready), 32'd0);
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    chk({tag, ".idle_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    logic [15:0] exp_alias;
    logic        exp_oor_err;
`ifdef MEM_ERR_CHECK_EN
    exp_alias = 16'h5A5A;
    exp_oor_err = 1'b1;
`else
    exp_alias = 16'hDEAD;
    exp_oor_err = 1'b0;
`endif

    repeat (3) step();
    chk("rst.rdata", 32'(rdata), 32'h0);
    chk("rst.busy", 32'(busy), 32'd0);
    reset = 1'b1;
    step();
    chk("rst.rdata_rel", 32'(rdata), 32'h0);
    chk("rst.ready", 32'(ready), 32'd0);
    chk("rst.busy_rel", 32'(busy), 32'd0);
    chk("rst.err", 32'(err), 32'd0);

    req("wr_a5", 1'b0, 16'h00A5, 16'hBEEF, 16'h0, 1'b0);
    chk("wr_a5.rdata_kept", 32'(rdata), 32'h0);
    req("rd_a5", 1'b1, 16'h00A5, 16'h0, 16'hBEEF, 1'b0);
    step();
    step();
    chk("rd_a5.held", 32'(rdata), 32'hBEEF);

    req("pre1", 1'b0, 16'h0001, 16'h1111, 16'h0, 1'b0);
    req("pre2", 1'b0, 16'h0002, 16'h2222, 16'h0, 1'b0);

    mem_en = 1'b1;
    read_wbar = 1'b1;
    addr = 16'h0001;
    step();
    step();
    chk("b2b.c2_ready", 32'(ready), 32'd0);
    step();
    chk("b2b.c3_ready", 32'(ready), 32'd1);
    chk("b2b.c3_rdata", 32'(rdata), 32'h1111);
    addr = 16'h0002;
    step();
    chk("b2b.c4_busy", 32'(busy), 32'd0);
    chk("b2b.c4_ready", 32'(ready), 32'd0);
    step();
    chk("b2b.c5_busy", 32'(busy), 32'd1);
    step();
    chk("b2b.c6_ready", 32'(ready), 32'd0);
    step();
    chk("b2b.c7_ready", 32'(ready), 32'd1);
    chk("b2b.c7_rdata", 32'(rdata), 32'h2222);
    mem_en = 1'b0;
    step();
    chk("b2b.c8_busy", 32'(busy), 32'd0);
    step();
    chk("b2b.c9_busy", 32'(busy), 32'd0);

    req("pre0", 1'b0, 16'h0000, 16'h5A5A, 16'h0, 1'b0);
    req("oor_wr", 1'b0, 16'h0100, 16'hDEAD, 16'h0, exp_oor_err);
    req("oor_rd0", 1'b1, 16'h0000, 16'h0, exp_alias, 1'b0);
`ifdef MEM_ERR_CHECK_EN
    req("oor_rd", 1'b1, 16'h0100, 16'h0, 16'h0000, 1'b1);
`endif

    req("pre10", 1'b0, 16'h0010, 16'h5555, 16'h0, 1'b0);
    mem_en = 1'b1;
    read_wbar = 1'b0;
    addr = 16'h0010;
    wdata = 16'h1234;
    step();
    chk("rstw.c1_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("rstw.busy", 32'(busy), 32'd0);
    mem_en = 1'b0;
    step();
    step();
    chk("rstw.ready", 32'(ready), 32'd0);
    reset = 1'b1;
    step();
    chk("rstw.rdata_clr", 32'(rdata), 32'h0);
    req("rstw.rd", 1'b1, 16'h0010, 16'h0, 16'h5555, 1'b0);
    req("rd_a5_again", 1'b1, 16'h00A5, 16'h0, 16'hBEEF, 1'b0);

    mem_en0 = 1'b1;
    read_wbar0 = 1'b0;
    addr0 = 16'h00C3;
    wdata0 = 16'h0077;
    chk("w0.c0_busy", 32'(busy0), 32'd0);
    step();
    chk("w0.wr_ready", 32'(ready0), 32'd1);
    chk("w0.wr_busy", 32'(busy0), 32'd1);
    mem_en0 = 1'b0;
    step();
    chk("w0.wr_idle", 32'(busy0), 32'd0);
    mem_en0 = 1'b1;
    read_wbar0 = 1'b1;
    step();
    chk("w0.rd_ready", 32'(ready0), 32'd1);
    chk("w0.rd_rdata", 32'(rdata0), 32'h0077);
    chk("w0.rd_err", 32'(err0), 32'd0);
    mem_en0 = 1'b0;
    step();
    chk("w0.c2_busy", 32'(busy0), 32'd0);
    chk("w0.c2_ready", 32'(ready0), 32'd0);
    chk("w0.c2_rdata", 32'(rdata0), 32'h0077);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
